spi_bus_arbiter: RTL and testbench
==================================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter MOSI_DATA_WIDTH, default 24, frame width in bits (16-bit instruction header plus data).
REQ-002 SHALL have parameter MISO_DATA_WIDTH, default 8, read data width; read buses are MISO_DATA_WIDTH+1 bits wide.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit in clk cycles.
REQ-004 SHALL have port clk, input, 1, single clock (20 MHz configuration clock).
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_wr_cmd, input, 3, write-request pulses; bit 0 = AD9517, bit 1 = ADC0, bit 2 = ADC1.
REQ-007 SHALL have port req_rd_cmd, input, 3, read-request pulses, same bit mapping.
REQ-008 SHALL have port req_wr_data, input, 3*MOSI_DATA_WIDTH, frame per requester; slice i at [i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH].
REQ-009 SHALL have port req_busy, output, 3, per-requester busy.
REQ-010 SHALL have port req_done, output, 3, one-cycle completion pulse per requester.
REQ-011 SHALL have port req_rd_data, output, 3*(MISO_DATA_WIDTH+1), read result per requester.
REQ-012 SHALL have ports m_wr_cmd and m_rd_cmd, output, 1 each, command pulses to the shared SPI master.
REQ-013 SHALL have port m_wr_data, output, MOSI_DATA_WIDTH, frame to the master.
REQ-014 SHALL have ports m_busy (1), m_rd_data (MISO_DATA_WIDTH+1), m_ncs (1), all inputs from the master.
REQ-015 SHALL have port dev_cs_n, output, 3, per-device chip selects: AD9517, ADC0, ADC1.
REQ-016 SHALL have port err_timeout, output, 1, sticky watchdog error flag.

Function
REQ-017 SHALL, when req_wr_cmd[i] or req_rd_cmd[i] is high while req_busy[i]=0, capture the frame and command type, set pending[i], and raise req_busy[i] on the next edge.
REQ-018 SHALL ignore commands from requester i while req_busy[i]=1; simultaneous wr and rd from one requester SHALL be treated as a write.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
REQ-020 SHALL, in IDLE with any pending bit set, grant round-robin starting at (last_grant+1) mod 3 and go to ISSUE; last_grant resets to 2, so AD9517 wins first.
REQ-021 SHALL, in ISSUE, drive m_wr_cmd or m_rd_cmd high for exactly one cycle with m_wr_data equal to the captured frame, then go to WAIT_START; m_wr_data SHALL hold until DONE.
REQ-022 SHALL leave WAIT_START for WAIT_DONE on m_busy=1, and WAIT_DONE for DONE on m_busy=0.
REQ-023 SHALL, in DONE, latch m_rd_data into slice g of req_rd_data for reads only, pulse req_done[g] for one cycle, clear pending[g] and req_busy[g], update last_grant, and return to IDLE.
REQ-024 SHALL drive dev_cs_n[g] = m_ncs while in any state other than IDLE, and drive every other bit high at all times.
REQ-025 SHALL achieve latency request edge N -> req_busy high at N+1 -> master command at N+2 or later when the bus is idle.
REQ-026 SHALL let a request arriving during another transfer wait; no requester SHALL be granted twice while another is pending.

Reset
REQ-027 SHALL, on rstn low and asynchronously, force state IDLE, pending=0, req_busy=0, req_done=0, req_rd_data=0, m_wr_cmd=0, m_rd_cmd=0, m_wr_data=0, dev_cs_n=3'b111, err_timeout=0, and last_grant=2, including mid-transfer.

Configuration
REQ-028 SHALL, with SPI_ARB_TIMEOUT_EN defined, count cycles in WAIT_START and WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL set err_timeout, pulse req_done[g] with req_rd_data unchanged, clear pending[g], and return to IDLE.
REQ-029 SHALL, without SPI_ARB_TIMEOUT_EN, omit the counter, wait indefinitely, and tie err_timeout to 0.

Verification
REQ-030 SHALL cover a single write: req_wr_cmd=3'b001 with data 0x000190 -> m_wr_cmd pulse with m_wr_data=0x000190, dev_cs_n[0] follows m_ncs, dev_cs_n[2:1]=2'b11, and one req_done[0] pulse.
REQ-031 SHALL cover a single read: ADC0 read 0x800100 with the master model returning 0x0AB -> ADC0 slice of req_rd_data=0x0AB, and the other slices unchanged.
REQ-032 SHALL cover simultaneous requests: all three pulsed together -> grants in order 0, 1, 2; a second burst of all three -> order 0, 1, 2 again.
REQ-033 SHALL cover a busy requester: a second req_wr_cmd[1] during an ADC0 transfer -> ignored, exactly one transfer.
REQ-034 SHALL cover reset mid-frame: rstn low in WAIT_DONE -> dev_cs_n=3'b111 and req_busy=0 with no clock edge, and pending cleared.
REQ-035 SHALL cover timeout with SPI_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: m_busy never rising -> err_timeout=1 after 16 cycles in WAIT_START, req_done pulsed, and state IDLE.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one SPI master between three requesters (0 = AD9517, 1 = ADC0,
// 2 = ADC1). Each requester posts a write or read command as a one-cycle
// pulse. The arbiter captures the frame and keeps the requester busy until
// its transfer finishes. Waiting requesters are granted round-robin, one
// transfer at a time. The granted device's chip select follows the master's
// m_ncs, and every other chip select stays high.
//
// Optional feature (macro SPI_ARB_TIMEOUT_EN): a watchdog counts cycles spent
// waiting on the master. After TIMEOUT_CYCLES it aborts the transfer and sets
// the sticky err_timeout flag. When the macro is not defined there is no
// watchdog and err_timeout is tied low.
//
// Ports
//   clk          in   configuration clock (20 MHz)
//   rstn         in   asynchronous active-low reset
//   req_wr_cmd   in   [2:0] write-request pulse per requester
//   req_rd_cmd   in   [2:0] read-request pulse per requester (wr wins if both)
//   req_wr_data  in   [3*MOSI_DATA_WIDTH-1:0] frame per requester
//   req_busy     out  [2:0] requester has a transfer queued or in flight
//   req_done     out  [2:0] one-cycle completion pulse per requester
//   req_rd_data  out  [3*(MISO_DATA_WIDTH+1)-1:0] last read result per requester
//   m_wr_cmd     out  write command pulse to the SPI master
//   m_rd_cmd     out  read command pulse to the SPI master
//   m_wr_data    out  [MOSI_DATA_WIDTH-1:0] frame to the master, held per transfer
//   m_busy       in   master transfer in progress
//   m_rd_data    in   [MISO_DATA_WIDTH:0] master read result
//   m_ncs        in   master chip select (active low)
//   dev_cs_n     out  [2:0] per-device chip selects
//   err_timeout  out  sticky watchdog error
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [2:0]                         req_wr_cmd,
  input  logic [2:0]                         req_rd_cmd,
  input  logic [3*MOSI_DATA_WIDTH-1:0]       req_wr_data,
  output logic [2:0]                         req_busy,
  output logic [2:0]                         req_done,
  output logic [3*(MISO_DATA_WIDTH+1)-1:0]   req_rd_data,
  output logic                               m_wr_cmd,
  output logic                               m_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]         m_wr_data,
  input  logic                               m_busy,
  input  logic [MISO_DATA_WIDTH:0]           m_rd_data,
  input  logic                               m_ncs,
  output logic [2:0]                         dev_cs_n,
  output logic                               err_timeout
);

  localparam int RW = MISO_DATA_WIDTH + 1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [1:0]                  r_grant;
  logic [1:0]                  r_last_grant;
  logic [1:0]                  w_pick;
  logic [2:0]                  r_pending;
  logic [2:0]                  r_is_rd;
  logic [2:0]                  r_done;
  logic [2:0]                  w_accept;
  logic                        w_grant_is_rd;
  logic                        w_timeout;
  logic [MOSI_DATA_WIDTH-1:0]  r_frame [3];
  logic [MOSI_DATA_WIDTH-1:0]  r_m_wr_data;
  logic [3*RW-1:0]             r_rd_data;

  // Round-robin pick: first pending requester after the last one served.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = last;
    // Walk from lowest priority to highest; the last hit is the winner.
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((32'(last) + k) % 3);
      if (pend[cand]) rr_pick = cand;
    end
  endfunction

  // A busy requester cannot post again until its transfer completes.
  assign w_accept = ~r_pending & (req_wr_cmd | req_rd_cmd);
  assign w_pick   = rr_pick(r_pending, r_last_grant);

  // ---------------------------------------------------------------------------
  // Optional watchdog on the master handshake
  // ---------------------------------------------------------------------------
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_err;
  logic             w_in_wait;

  assign w_in_wait = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);
  // Fires on the last permitted waiting cycle; the FSM leaves on that edge.
  assign w_timeout = w_in_wait && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_in_wait) r_wd_cnt <= r_wd_cnt + 1'b1;
      else           r_wd_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame capture
  // ---------------------------------------------------------------------------
  // NOTE: frame storage has no reset; an entry is only read after its pending
  // bit has been set, and that happens on the same edge that writes the entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_accept[i]) r_frame[i] <= req_wr_data[i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // State register and transfer bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd2;
      r_pending    <= '0;
      r_is_rd      <= '0;
      r_done       <= '0;
      r_rd_data    <= '0;
      r_m_wr_data  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= '0;

      for (int i = 0; i < 3; i++) begin
        if (w_accept[i]) begin
          r_pending[i] <= 1'b1;
          r_is_rd[i]   <= ~req_wr_cmd[i];
        end
      end

      if (r_state == S_IDLE && |r_pending) begin
        r_grant     <= w_pick;
        r_m_wr_data <= r_frame[w_pick];
      end

      // Completion and watchdog abort both release the granted requester;
      // only a real completion returns read data and advances the rotation.
      if (r_state == S_DONE || w_timeout) begin
        for (int i = 0; i < 3; i++) begin
          if (r_grant == 2'(i)) begin
            r_done[i]    <= 1'b1;
            r_pending[i] <= 1'b0;
            if (r_state == S_DONE && r_is_rd[i]) r_rd_data[i*RW +: RW] <= m_rd_data;
          end
        end
        if (r_state == S_DONE) r_last_grant <= r_grant;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (|r_pending) w_next = S_ISSUE;
      S_ISSUE:      w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (w_timeout)   w_next = S_IDLE;
        else if (m_busy) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE:  begin
        if (w_timeout)    w_next = S_IDLE;
        else if (!m_busy) w_next = S_DONE;
      end
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_is_rd = 1'b0;
    dev_cs_n      = 3'b111;
    for (int i = 0; i < 3; i++) begin
      if (r_grant == 2'(i)) begin
        w_grant_is_rd = r_is_rd[i];
        // Chip select reaches the device only while its transfer owns the bus.
        if (r_state != S_IDLE) dev_cs_n[i] = m_ncs;
      end
    end
  end

  assign m_wr_cmd    = (r_state == S_ISSUE) && !w_grant_is_rd;
  assign m_rd_cmd    = (r_state == S_ISSUE) &&  w_grant_is_rd;
  assign m_wr_data   = r_m_wr_data;
  assign req_busy    = r_pending;
  assign req_done    = r_done;
  assign req_rd_data = r_rd_data;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

  localparam int MW = 24;
  localparam int RW = 9;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [2:0]        req_wr_cmd, req_rd_cmd;
  logic [3*MW-1:0]   req_wr_data;
  logic [2:0]        req_busy, req_done;
  logic [3*RW-1:0]   req_rd_data;
  logic              m_wr_cmd, m_rd_cmd;
  logic [MW-1:0]     m_wr_data;
  logic              m_busy, m_ncs;
  logic [RW-1:0]     m_rd_data;
  logic [2:0]        dev_cs_n;
  logic              err_timeout;

  spi_bus_arbiter #(
    .MOSI_DATA_WIDTH(MW),
    .MISO_DATA_WIDTH(RW-1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_wr_cmd (req_wr_cmd),
    .req_rd_cmd (req_rd_cmd),
    .req_wr_data(req_wr_data),
    .req_busy   (req_busy),
    .req_done   (req_done),
    .req_rd_data(req_rd_data),
    .m_wr_cmd   (m_wr_cmd),
    .m_rd_cmd   (m_rd_cmd),
    .m_wr_data  (m_wr_data),
    .m_busy     (m_busy),
    .m_rd_data  (m_rd_data),
    .m_ncs      (m_ncs),
    .dev_cs_n   (dev_cs_n),
    .err_timeout(err_timeout)
  );

  always #25 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: who is waiting, what they asked for, and the timeline
  // of the transfer currently owning the bus.
  logic [2:0]      mp;
  logic [MW-1:0]   mfr [3];
  logic [2:0]      mrd;
  int              mlast;
  bit              act;
  int              g, k_cyc, done_due, d1, d2;
  bit              cur_tmo;
  logic [MW-1:0]   exp_wr_data;
  logic [3*RW-1:0] exp_rd;
  bit              exp_err;
  logic [RW-1:0]   bfm_rd;

  // Stimulus knobs
  bit              tmo_mode;
  int              fix_d1, fix_d2;
  bit              use_fix_rd;
  logic [RW-1:0]   fix_rd;

  // Observations of the DUT, pinned against literal values in directed tests
  int              dut_wr_cmds, dut_rd_cmds;
  logic [MW-1:0]   last_cmd_data;
  int              done_ord;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [2:0] pend, input int last);
    int idx;
    for (int off = 1; off <= 3; off++) begin
      idx = (last + off) % 3;
      if (pend[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic drive_req(input int i, input bit wr, input bit rd, input logic [MW-1:0] data);
    req_wr_cmd[i] = wr;
    req_rd_cmd[i] = rd;
    req_wr_data[i*MW +: MW] = data;
  endtask

  // One clock cycle: advance the model over the posedge, compare all outputs,
  // then drive the master model and retire one-cycle request pulses.
  task automatic tick();
    logic [2:0]      a_wr, a_rd, mp_prev, exp_done, exp_cs;
    logic [3*MW-1:0] a_data;
    int              last_prev;
    bit              idle_prev;
    a_wr   = req_wr_cmd;
    a_rd   = req_rd_cmd;
    a_data = req_wr_data;
    @(negedge clk);
    cyc++;
    mp_prev   = mp;
    last_prev = mlast;
    idle_prev = !act;
    exp_done  = '0;

    if (act && cyc == done_due) begin
      exp_done[g] = 1'b1;
      mp[g] = 1'b0;
      if (cur_tmo) exp_err = 1'b1;
      else begin
        mlast = g;
        if (mrd[g]) exp_rd[g*RW +: RW] = bfm_rd;
      end
      act = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      if (!mp_prev[i] && (a_wr[i] || a_rd[i])) begin
        mp[i]  = 1'b1;
        mfr[i] = a_data[i*MW +: MW];
        mrd[i] = !a_wr[i];
      end
    end

    if (idle_prev && mp_prev != 3'b000) begin
      g           = rr_next(mp_prev, last_prev);
      act         = 1'b1;
      k_cyc       = cyc;
      exp_wr_data = mfr[g];
      cur_tmo     = tmo_mode;
      d1          = (fix_d1 > 0) ? fix_d1 : int'($urandom_range(1, 3));
      d2          = (fix_d2 > 0) ? fix_d2 : int'($urandom_range(1, 4));
      bfm_rd      = use_fix_rd ? fix_rd : RW'($urandom);
      done_due    = cur_tmo ? cyc + TO + 1 : cyc + d1 + d2 + 2;
    end

    exp_cs = 3'b111;
    if (act) exp_cs[g] = m_ncs;
    check("req_busy",    64'(req_busy),    64'(mp));
    check("req_done",    64'(req_done),    64'(exp_done));
    check("req_rd_data", 64'(req_rd_data), 64'(exp_rd));
    check("m_wr_cmd",    64'(m_wr_cmd),    64'(act && cyc == k_cyc && !mrd[g]));
    check("m_rd_cmd",    64'(m_rd_cmd),    64'(act && cyc == k_cyc &&  mrd[g]));
    check("m_wr_data",   64'(m_wr_data),   64'(exp_wr_data));
    check("dev_cs_n",    64'(dev_cs_n),    64'(exp_cs));
    check("err_timeout", 64'(err_timeout), 64'(exp_err));

    if (m_wr_cmd) begin dut_wr_cmds++; last_cmd_data = m_wr_data; end
    if (m_rd_cmd) begin dut_rd_cmds++; last_cmd_data = m_wr_data; end
    for (int i = 0; i < 3; i++) if (req_done[i]) done_ord = done_ord * 16 + i + 1;

    if (act && !cur_tmo) begin
      m_busy    = (cyc >= k_cyc + d1) && (cyc < k_cyc + d1 + d2);
      m_rd_data = bfm_rd;
    end else begin
      m_busy = 1'b0;
    end
    m_ncs      = !m_busy;
    req_wr_cmd = '0;
    req_rd_cmd = '0;
  endtask

  task automatic run_until_quiet(input string name, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((act || mp != 3'b000) && n < budget);
    check(name, 64'(act || mp != 3'b000), 64'd0);
  endtask

  task automatic apply_reset();
    #2 rstn = 1'b0;
    req_wr_cmd  = '0;
    req_rd_cmd  = '0;
    m_busy      = 1'b0;
    m_ncs       = 1'b1;
    mp          = '0;
    mrd         = '0;
    mlast       = 2;
    act         = 1'b0;
    cur_tmo     = 1'b0;
    exp_wr_data = '0;
    exp_rd      = '0;
    exp_err     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    int kind;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          kind = int'($urandom_range(0, 2));
          drive_req(i, kind != 1, kind != 0, MW'($urandom));
        end
      end
      tick();
    end
    run_until_quiet("random_drain", 200);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn        = 1'b0;
    req_wr_cmd  = '0;
    req_rd_cmd  = '0;
    req_wr_data = '0;
    m_busy      = 1'b0;
    m_ncs       = 1'b1;
    m_rd_data   = '0;
    tmo_mode    = 1'b0;
    fix_d1      = 0;
    fix_d2      = 0;
    use_fix_rd  = 1'b0;
    fix_rd      = '0;
    dut_wr_cmds = 0;
    dut_rd_cmds = 0;
    done_ord    = 0;
    g           = 0;
    k_cyc       = -10;
    done_due    = -10;
    apply_reset();

    // Reset values
    check("rst_req_busy",    64'(req_busy),    64'h0);
    check("rst_req_done",    64'(req_done),    64'h0);
    check("rst_req_rd_data", 64'(req_rd_data), 64'h0);
    check("rst_m_wr_cmd",    64'(m_wr_cmd),    64'h0);
    check("rst_m_rd_cmd",    64'(m_rd_cmd),    64'h0);
    check("rst_m_wr_data",   64'(m_wr_data),   64'h0);
    check("rst_dev_cs_n",    64'(dev_cs_n),    64'h7);
    check("rst_err_timeout", 64'(err_timeout), 64'h0);

    // Two bursts of simultaneous requests: served 0,1,2 each time
    for (int b = 0; b < 2; b++) begin
      done_ord = 0;
      for (int i = 0; i < 3; i++) drive_req(i, 1'b1, 1'b0, MW'(24'h100000 * (i + 1) + b));
      tick();
      check("burst_all_busy", 64'(req_busy), 64'h7);
      run_until_quiet("burst_drain", 100);
      check("burst_order", 64'(done_ord), 64'h123);
    end

    // Single write from AD9517
    done_ord = 0; dut_wr_cmds = 0;
    drive_req(0, 1'b1, 1'b0, 24'h000190);
    run_until_quiet("single_wr_drain", 50);
    check("single_wr_data",  64'(last_cmd_data), 64'h000190);
    check("single_wr_count", 64'(dut_wr_cmds),   64'd1);
    check("single_wr_done",  64'(done_ord),      64'h1);

    // Single read from ADC0 returning 0x0AB
    use_fix_rd = 1'b1; fix_rd = 9'h0AB; dut_rd_cmds = 0;
    drive_req(1, 1'b0, 1'b1, 24'h800100);
    run_until_quiet("single_rd_drain", 50);
    use_fix_rd = 1'b0;
    check("single_rd_cmd_data", 64'(last_cmd_data),         64'h800100);
    check("single_rd_count",    64'(dut_rd_cmds),           64'd1);
    check("single_rd_adc0",     64'(req_rd_data[RW +: RW]), 64'h0AB);
    check("single_rd_ad9517",   64'(req_rd_data[0 +: RW]),  64'h0);
    check("single_rd_adc1",     64'(req_rd_data[2*RW +: RW]), 64'h0);

    // Second command from a busy requester is ignored
    fix_d1 = 2; fix_d2 = 3; done_ord = 0; dut_wr_cmds = 0;
    drive_req(1, 1'b1, 1'b0, 24'h123456);
    repeat (3) tick();
    drive_req(1, 1'b1, 1'b0, 24'h654321);
    run_until_quiet("busy_drain", 50);
    check("busy_one_transfer", 64'(dut_wr_cmds),   64'd1);
    check("busy_frame",        64'(last_cmd_data), 64'h123456);
    check("busy_done",         64'(done_ord),      64'h2);

    // Write and read together count as a write
    dut_wr_cmds = 0; dut_rd_cmds = 0;
    drive_req(2, 1'b1, 1'b1, 24'hABCDEF);
    run_until_quiet("wr_rd_drain", 50);
    check("wr_rd_as_write", 64'({dut_wr_cmds[7:0], dut_rd_cmds[7:0]}), 64'h0100);

    // Reset while the master is mid-frame
    fix_d1 = 1; fix_d2 = 6;
    drive_req(2, 1'b1, 1'b0, 24'h0F0F0F);
    repeat (5) tick();
    check("mid_cs_before",   64'(dev_cs_n), 64'h3);
    check("mid_busy_before", 64'(req_busy), 64'h4);
    #2 rstn = 1'b0;
    #1;
    check("mid_cs_async",   64'(dev_cs_n),  64'h7);
    check("mid_busy_async", 64'(req_busy),  64'h0);
    check("mid_wdata_async",64'(m_wr_data), 64'h0);
    apply_reset();
    fix_d1 = 0; fix_d2 = 0;
    repeat (5) tick();
    done_ord = 0;
    drive_req(1, 1'b1, 1'b0, 24'h000011);
    drive_req(2, 1'b1, 1'b0, 24'h000022);
    run_until_quiet("post_reset_drain", 60);
    check("post_reset_order", 64'(done_ord), 64'h23);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never responds: watchdog aborts after TO waiting cycles
    tmo_mode = 1'b1; done_ord = 0;
    drive_req(0, 1'b0, 1'b1, 24'h8000AA);
    run_until_quiet("timeout_drain", 60);
    tmo_mode = 1'b0;
    check("timeout_err",  64'(err_timeout),          64'h1);
    check("timeout_done", 64'(done_ord),             64'h1);
    check("timeout_rd",   64'(req_rd_data[0 +: RW]), 64'h0);
`endif

    random_phase(3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
